// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/LSU AXI arbiter; response codes follow axi4_types.
package mem_arb_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
  typedef enum logic [2:0] {IDLE, AR, R, WR, B, ERR} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic size_e norm_size(input logic [1:0] sz);
    return sz[1] ? SZ_WORD : size_e'(sz);
  endfunction
endpackage

// File: rtl/lsu_wstrb_gen.sv
// lsu_wstrb_gen: byte-lane strobes, replicated write data and alignment check for one access.
module lsu_wstrb_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misalign
);
  assign wstrb = size == SZ_BYTE ? 4'b0001 << addr :
                 size == SZ_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                     size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign misalign = size == SZ_HALF ? addr[0] :
                    size == SZ_WORD ? |addr : 1'b0;
endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: round-robin share of one single-beat AXI4 master between fetch and LSU.
module axi_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [1:0]            ls_size_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [2:0]            m_arsize_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [ADDR_WIDTH-1:0] m_awaddr_o,
  output logic [2:0]            m_awsize_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [3:0]            m_wstrb_o,
  output logic                  m_wlast_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o
);
  state_e state, state_n;
  owner_e last, last_n, owner, owner_n, pick;
  size_e sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr, araddr_n, awaddr_n;
  logic [DATA_WIDTH-1:0] rdata_n, wdata_n, rep;
  logic [2:0] arsize_n, awsize_n;
  logic [3:0] wstrb_n, strb;
  logic mis, if_gnt_n, ls_gnt_n, if_rv_n, ls_rv_n, err_n;
  logic arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  // last holds the most recent winner, so a tie goes to the other requester
  assign pick = (if_req_i && ls_req_i) ? (last == OWN_IF ? OWN_LS : OWN_IF) :
                (if_req_i ? OWN_IF : OWN_LS);
  assign sel_size = pick == OWN_IF ? SZ_WORD : norm_size(ls_size_i);
  assign sel_addr = pick == OWN_IF ? if_addr_i : ls_addr_i;
  assign m_wlast_o = m_wvalid_o;
  lsu_wstrb_gen u_gen (
    .size(sel_size), .addr(sel_addr[1:0]), .wdata(ls_wdata_i),
    .wstrb(strb), .wdata_rep(rep), .misalign(mis)
  );
  always_comb begin
    state_n = state;
    last_n = last;
    owner_n = owner;
    if_gnt_n = 1'b0;
    ls_gnt_n = 1'b0;
    if_rv_n = 1'b0;
    ls_rv_n = 1'b0;
    rdata_n = rdata_o;
    err_n = err_o;
    araddr_n = m_araddr_o;
    arsize_n = m_arsize_o;
    arvalid_n = m_arvalid_o;
    rready_n = m_rready_o;
    awaddr_n = m_awaddr_o;
    awsize_n = m_awsize_o;
    awvalid_n = m_awvalid_o;
    wdata_n = m_wdata_o;
    wstrb_n = m_wstrb_o;
    wvalid_n = m_wvalid_o;
    bready_n = m_bready_o;
    case (state)
      IDLE: if (if_req_i || ls_req_i) begin
        owner_n = pick;
        last_n = pick;
        if_gnt_n = pick == OWN_IF;
        ls_gnt_n = pick == OWN_LS;
        if (mis) state_n = ERR;
        else if (pick == OWN_LS && ls_we_i) begin
          awaddr_n = ls_addr_i;
          awsize_n = {1'b0, sel_size};
          awvalid_n = 1'b1;
          wdata_n = rep;
          wstrb_n = strb;
          wvalid_n = 1'b1;
          state_n = WR;
        end else begin
          araddr_n = sel_addr;
          arsize_n = {1'b0, sel_size};
          arvalid_n = 1'b1;
          state_n = AR;
        end
      end
      ERR: begin
        if_rv_n = owner == OWN_IF;
        ls_rv_n = owner == OWN_LS;
        rdata_n = '0;
        err_n = 1'b1;
        state_n = IDLE;
      end
      AR: if (m_arready_i) begin
        arvalid_n = 1'b0;
        rready_n = 1'b1;
        state_n = R;
      end
      R: if (m_rvalid_i) begin
        if_rv_n = owner == OWN_IF;
        ls_rv_n = owner == OWN_LS;
        rdata_n = m_rdata_i;
        err_n = m_rresp_i >= RESP_SLVERR;
        rready_n = 1'b0;
        state_n = IDLE;
      end
      WR: begin
        if (m_awready_i) awvalid_n = 1'b0;
        if (m_wready_i) wvalid_n = 1'b0;
        if ((!m_awvalid_o || m_awready_i) && (!m_wvalid_o || m_wready_i)) begin
          bready_n = 1'b1;
          state_n = B;
        end
      end
      B: if (m_bvalid_i) begin
        ls_rv_n = 1'b1;
        err_n = m_bresp_i >= RESP_SLVERR;
        bready_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      last <= OWN_LS;
      owner <= OWN_IF;
      if_gnt_o <= 1'b0;
      ls_gnt_o <= 1'b0;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
      m_araddr_o <= '0;
      m_arsize_o <= '0;
      m_arvalid_o <= 1'b0;
      m_rready_o <= 1'b0;
      m_awaddr_o <= '0;
      m_awsize_o <= '0;
      m_awvalid_o <= 1'b0;
      m_wdata_o <= '0;
      m_wstrb_o <= '0;
      m_wvalid_o <= 1'b0;
      m_bready_o <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      owner <= owner_n;
      if_gnt_o <= if_gnt_n;
      ls_gnt_o <= ls_gnt_n;
      if_rvalid_o <= if_rv_n;
      ls_rvalid_o <= ls_rv_n;
      rdata_o <= rdata_n;
      err_o <= err_n;
      m_araddr_o <= araddr_n;
      m_arsize_o <= arsize_n;
      m_arvalid_o <= arvalid_n;
      m_rready_o <= rready_n;
      m_awaddr_o <= awaddr_n;
      m_awsize_o <= awsize_n;
      m_awvalid_o <= awvalid_n;
      m_wdata_o <= wdata_n;
      m_wstrb_o <= wstrb_n;
      m_wvalid_o <= wvalid_n;
      m_bready_o <= bready_n;
    end
  end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed checks of arbitration, AXI channel sequencing, lanes and errors.
module tb_axi_mem_arbiter;
  logic ACLK = 1'b0, ARESET = 1'b0;
  logic if_req_i = 1'b0, ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, ls_addr_i = '0, ls_wdata_i = '0;
  logic [1:0] ls_size_i = '0;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, err_o;
  logic [31:0] rdata_o, m_araddr_o, m_awaddr_o, m_wdata_o;
  logic [2:0] m_arsize_o, m_awsize_o;
  logic m_arvalid_o, m_rready_o, m_awvalid_o, m_wlast_o, m_wvalid_o, m_bready_o;
  logic [3:0] m_wstrb_o;
  logic m_arready_i = 1'b0, m_rvalid_i = 1'b0, m_awready_i = 1'b0, m_wready_i = 1'b0, m_bvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;
  logic [1:0] m_rresp_i = '0, m_bresp_i = '0;
  int checks = 0, failures = 0;

  always #5 ACLK = ~ACLK;

  axi_mem_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .m_araddr_o(m_araddr_o), .m_arsize_o(m_arsize_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_awaddr_o(m_awaddr_o), .m_awsize_o(m_awsize_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #1 ARESET = 1'b1;
    #1;
    chk("rst_gnt", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o}, 4'b0);
    chk("rst_valids", {m_arvalid_o, m_awvalid_o, m_wvalid_o, m_wlast_o, m_rready_o, m_bready_o}, 6'b0);
    chk("rst_data", {rdata_o, err_o}, 33'b0);
    tick();
    tick();
    ARESET = 1'b0;
    // single fetch, zero-wait slave
    m_arready_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF; m_rresp_i = 2'b00;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    chk("f_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
    chk("f_ar", {m_arvalid_o, m_arsize_o, m_araddr_o}, {1'b1, 3'd2, 32'h100});
    if_req_i = 1'b0;
    tick();
    chk("f_r", {if_gnt_o, m_arvalid_o, m_rready_o, if_rvalid_o}, 4'b0010);
    tick();
    chk("f_resp", {if_rvalid_o, ls_rvalid_o, err_o, m_rready_o, rdata_o}, {4'b1000, 32'hDEADBEEF});
    tick();
    chk("f_done", {if_rvalid_o, m_arvalid_o}, 2'b00);
    // byte store at 0x203
    m_awready_i = 1'b1; m_wready_i = 1'b1; m_bvalid_i = 1'b1; m_bresp_i = 2'b00;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'b00; ls_addr_i = 32'h203; ls_wdata_i = 32'hA5;
    tick();
    chk("sb_gnt", {if_gnt_o, ls_gnt_o, m_arvalid_o}, 3'b010);
    chk("sb_aw", {m_awvalid_o, m_awsize_o, m_awaddr_o}, {1'b1, 3'd0, 32'h203});
    chk("sb_w", {m_wvalid_o, m_wlast_o, m_wstrb_o, m_wdata_o}, {2'b11, 4'b1000, 32'hA5A5A5A5});
    ls_req_i = 1'b0;
    tick();
    chk("sb_b", {m_awvalid_o, m_wvalid_o, m_bready_o, ls_rvalid_o}, 4'b0010);
    tick();
    chk("sb_resp", {ls_rvalid_o, if_rvalid_o, err_o, m_bready_o, rdata_o}, {4'b1000, 32'hDEADBEEF});
    tick();
    chk("sb_done", ls_rvalid_o, 1'b0);
    // contention: last grant was LSU, so fetch wins first
    if_req_i = 1'b1; if_addr_i = 32'h0;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_addr_i = 32'h40;
    for (int i = 0; i < 4; i++) begin
      m_rdata_i = 32'h1000 + i;
      tick();
      chk("c_gnt", {if_gnt_o, ls_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("c_addr", m_araddr_o, (i % 2 == 0) ? 32'h0 : 32'h40);
      tick();
      chk("c_single", {if_gnt_o, ls_gnt_o, m_arvalid_o, m_rready_o, m_awvalid_o}, 5'b00010);
      if (i == 3) begin if_req_i = 1'b0; ls_req_i = 1'b0; end
      tick();
      chk("c_resp", {if_rvalid_o, ls_rvalid_o, rdata_o}, {(i % 2 == 0) ? 2'b10 : 2'b01, 32'h1000 + i});
    end
    tick();
    chk("c_idle", {if_gnt_o, ls_gnt_o, m_arvalid_o, if_rvalid_o, ls_rvalid_o}, 5'b0);
    // half store, AWREADY delayed 3 cycles, SLVERR
    m_awready_i = 1'b0; m_wready_i = 1'b1; m_bresp_i = 2'b10;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'b01; ls_addr_i = 32'h42; ls_wdata_i = 32'h1234;
    tick();
    chk("hw_gnt", {ls_gnt_o, m_awvalid_o, m_wvalid_o, m_awsize_o}, {3'b111, 3'd1});
    chk("hw_lanes", {m_wstrb_o, m_wdata_o}, {4'b1100, 32'h12341234});
    ls_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hw_hold", {m_awvalid_o, m_wvalid_o, m_bready_o, m_awaddr_o}, {3'b100, 32'h42});
    end
    m_awready_i = 1'b1;
    tick();
    chk("hw_b", {m_awvalid_o, m_wvalid_o, m_bready_o, ls_rvalid_o}, 4'b0010);
    tick();
    chk("hw_err", {ls_rvalid_o, err_o, m_bready_o}, 3'b110);
    tick();
    // misaligned half load
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b01; ls_addr_i = 32'h101;
    tick();
    chk("mis_gnt", {ls_gnt_o, m_arvalid_o, m_awvalid_o, m_wvalid_o}, 4'b1000);
    ls_req_i = 1'b0;
    tick();
    chk("mis_resp", {ls_rvalid_o, if_rvalid_o, err_o, m_arvalid_o, rdata_o}, {4'b1010, 32'h0});
    tick();
    chk("mis_done", {ls_rvalid_o, m_arvalid_o}, 2'b00);
    // reset while waiting in R
    m_rvalid_i = 1'b0; m_rresp_i = 2'b00;
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    chk("rr_gnt", if_gnt_o, 1'b1);
    if_req_i = 1'b0;
    tick();
    chk("rr_in_r", m_rready_o, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    chk("rr_async", {m_rready_o, if_gnt_o, if_rvalid_o, ls_rvalid_o, err_o, m_arvalid_o}, 6'b0);
    tick();
    ARESET = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFEF00D;
    if_req_i = 1'b1; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_addr_i = 32'h80;
    tick();
    chk("rr_regnt", {if_gnt_o, ls_gnt_o, m_araddr_o}, {2'b10, 32'h300});
    if_req_i = 1'b0; ls_req_i = 1'b0;
    tick();
    tick();
    chk("rr_resp", {if_rvalid_o, err_o, rdata_o}, {2'b10, 32'hCAFEF00D});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
Shares one single-beat AXI4 master port between instruction fetch (read-only, word) and the LSU (read/write, byte/half/word).
- Round-robin arbitration.
- One outstanding transaction in total.
- Generates AxSIZE, WSTRB and lane-replicated WDATA.
- Reports completion and errors back to the owning requester.

Parameters:
ADDR_WIDTH, 32, address width of requesters and AXI
DATA_WIDTH, 32, data width; must be 32 (4 byte lanes)

Ports:
ACLK  in  1  clock
ARESET  in  1  reset
if_req_i / if_addr_i  in  1 / ADDR_WIDTH  fetch request and address, held until if_gnt_o
if_gnt_o / if_rvalid_o  out  1 / 1  fetch grant pulse; fetch completion pulse
ls_req_i / ls_we_i / ls_size_i  in  1 / 1 / 2  LSU request, write enable, size (00 byte, 01 half, 1x word)
ls_addr_i / ls_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  LSU address and write data, held until ls_gnt_o
ls_gnt_o / ls_rvalid_o  out  1 / 1  LSU grant pulse; LSU completion pulse (read data or write ack)
rdata_o / err_o  out  DATA_WIDTH / 1  shared response data and error, valid with either rvalid pulse
m_araddr_o / m_arsize_o / m_arvalid_o / m_arready_i  out,out,out,in  ADDR_WIDTH / 3 / 1 / 1  AR channel
m_rdata_i / m_rresp_i / m_rvalid_i / m_rready_o  in,in,in,out  DATA_WIDTH / 2 / 1 / 1  R channel
m_awaddr_o / m_awsize_o / m_awvalid_o / m_awready_i  out,out,out,in  ADDR_WIDTH / 3 / 1 / 1  AW channel
m_wdata_o / m_wstrb_o / m_wlast_o / m_wvalid_o / m_wready_i  out,out,out,out,in  DATA_WIDTH / 4 / 1 / 1 / 1  W channel
m_bresp_i / m_bvalid_i / m_bready_o  in,in,out  2 / 1 / 1  B channel
Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- **Registered outputs:** all outputs are registered except m_wlast_o, which is defined as m_wlast_o = m_wvalid_o.
- **Reset (asynchronous, immediate):**
  - all outputs go to 0.
  - state goes to IDLE.
  - round-robin pointer is set so fetch wins the first tie.
  - an in-flight transaction is abandoned; requesters must reissue.
- **States:** IDLE, AR, R, WR, B, ERR.
- **IDLE:**
  - Samples both requests.
  - If both are high, the requester not granted last wins.
  - On the edge that accepts a request:
    - the winner's gnt is pulsed for 1 cycle;
    - address, size, we and wdata are captured;
    - the pointer is updated.
  - Fetch always uses size word and we=0.
  - A requester may drop req before grant without effect.
- **Alignment check (at grant):**
  - An error occurs if a half access has addr[0]=1, or a word access has addr[1:0]≠0 (including fetch).
  - On error → ERR: no AXI traffic; the owner's rvalid is pulsed next cycle with err_o=1 and rdata_o=0; → IDLE.
- **AR:**
  - m_arvalid_o=1, with m_araddr_o and m_arsize_o={1'b0,size} stable.
  - On arvalid&&arready: arvalid←0, rready←1, → R.
- **R:**
  - On rvalid&&rready: rdata_o←RDATA (raw, no sign extension), err_o←RRESP[1], owner rvalid pulsed 1 cycle, rready←0, → IDLE.
- **WR:**
  - AWVALID and WVALID both rise on entry.
  - Each drops independently on its own handshake; simultaneous or either order is allowed.
  - When both are done: bready←1, → B.
- **B:**
  - On bvalid&&bready: ls_rvalid_o pulsed, err_o←BRESP[1], rdata_o unchanged, bready←0, → IDLE.
- **Write lanes:**
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001<<addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011<<(2·addr[1]).
  - word: wdata unchanged, wstrb = 1111.
- **AXI rule:** payload is stable while valid is high and until the handshake.
- **Latency (zero-wait slave):**
  - Read: request seen at edge N → gnt and ARVALID after N; response pulse after edge N+2.
  - Write: response pulse after edge N+2.
  - At least one IDLE cycle separates consecutive transactions.
- **Response ordering:** stray m_rvalid_i or m_bvalid_i outside R/B is ignored (ready is low).

Decomposition:
- Package mem_arb_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - owner enum (OWN_IF, OWN_LS).
- Response codes are taken from axi4_types.
- One combinational sub-module, lsu_wstrb_gen: inputs size and addr[1:0]; outputs wstrb, replicated wdata and misalign flag. It is also reused for the read-side alignment check.

Test Plan:
- **Single fetch:** if_req_i=1, addr 0x100; slave returns RDATA 0xDEADBEEF with OKAY → ARSIZE=2, one if_gnt_o, if_rvalid_o 2 cycles after grant, rdata_o=0xDEADBEEF, err_o=0.
- **Byte store:** LSU store byte, addr 0x203, data 0x000000A5 → AWSIZE=0, WSTRB=1000, WDATA=0xA5A5A5A5, one ls_rvalid_o after BVALID, err_o=0.
- **Contention:** if_req_i and ls_req_i held high for 4 transactions → grants IF, LS, IF, LS; never two outstanding.
- **Channel order and write error:** AWREADY delayed 3 cycles while WREADY is immediate → WVALID drops first, AWVALID holds until its handshake; BRESP=SLVERR → err_o=1.
- **Misaligned half load:** addr 0x101 → no ARVALID, ls_rvalid_o with err_o=1 one cycle after grant.
- **Reset mid-read:** ARESET asserted while in R → m_rready_o and all pulses go to 0 immediately; after release a fresh fetch completes normally.
